blk_a1b057: RTL and testbench
=============================

Name: output_drainer_q_fp32_output_mmap_m_axi_fifo_ctrl

Overview:
- Show-ahead FIFO that buffers m_axi output-path data (write-channel beats or response tokens) between the output drainer and the AXI master port.
- Storage is a shift-register array of DEPTH-1 entries. The block instantiates the team's SRL storage cell for it, or implements an equivalent array.
- A registered output stage holds one more entry, so total capacity is DEPTH.
- The block owns all occupancy tracking, read-address generation, full/empty flags and the write-bypass path.

Parameters:
- DATA_WIDTH, 32: payload width in bits.
- ADDR_WIDTH, 6: SRL read-address width. Must satisfy 2^ADDR_WIDTH >= DEPTH-1.
- DEPTH, 64: total capacity in entries (SRL plus output register). Must be >= 2.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  producer data.
- if_full_n  out  1  high when there is space for at least one entry.
- if_read  in  1  consumer read/pop request.
- if_dout  out  DATA_WIDTH  head-of-FIFO data; valid while if_empty_n is high.
- if_empty_n  out  1  high when if_dout holds valid data.
- num_data_valid  out  ADDR_WIDTH+1  total entries held (SRL plus output register), range 0..DEPTH.
- fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ap_rst_n).
  - While ap_rst_n is low: if_empty_n=0, if_full_n=1, if_dout=0, num_data_valid=0, internal SRL count=0.
  - SRL contents are not reset.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Handshakes:
  - push = if_write & if_full_n.
  - pop = if_read & if_empty_n.
  - Requests made while the flag is low are ignored with no state change.
- State:
  - n_srl (0..DEPTH-1) = entries in the SRL.
  - dout_valid drives if_empty_n.
  - num_data_valid = n_srl + dout_valid, held in a register.
- SRL write: on push, unless bypass is taken, din shifts into mem[0]; older entries move up one place.
- Output stage loads when it is free, i.e. (!dout_valid | pop):
  - If n_srl>0: if_dout <= mem[n_srl-1]. This index uses the pre-edge n_srl and pre-shift contents, so a simultaneous push is safe. n_srl decrements, or stays the same if a push also lands in the SRL.
  - Else if push (bypass): if_dout <= if_din and dout_valid=1. The SRL is untouched.
  - Else: dout_valid <= 0. if_dout holds its last value.
- Latency:
  - Write into an empty FIFO to if_empty_n high: 1 cycle.
  - Pop to next head visible: 0 extra cycles, because the next entry appears on the edge that consumes the current one.
- Occupancy update: num_data_valid changes by +1 on push only, -1 on pop only, 0 on both or neither.
- if_full_n is registered:
  - Goes to 0 on the edge where num_data_valid becomes DEPTH.
  - Returns to 1 on the edge following a pop from full.
- Full with if_write and if_read both high:
  - pop occurs; push does not, because if_full_n=0.
  - Result is DEPTH-1 entries and if_full_n=1.
- Empty with if_write and if_read both high: only push occurs, via bypass.
- FIFO order is strict. There is no overflow or underflow; the counters never wrap.

Test Plan:
- Reset, then write 0x11 in cycle 0 -> if_empty_n=1 and if_dout=0x11 at cycle 1; num_data_valid=1.
- With if_read low, write 0x00..0x3F, one per cycle, 64 writes -> if_full_n falls after the 64th write; num_data_valid=64; a 65th write of 0xAA is ignored.
- From full, assert if_read continuously -> 0x00..0x3F out, one per cycle, in order; if_full_n=1 after the first pop; if_empty_n=0 after the last pop; num_data_valid=0.
- Hold occupancy at 3 (entries 0x1,0x2,0x3) and push+pop every cycle with 0x4,0x5,... -> outputs 0x1,0x2,0x3,0x4,... with no gaps; num_data_valid stays at 3.
- Full plus simultaneous if_write/if_read -> one pop, no push; num_data_valid=63; if_full_n=1 next cycle.
- Drive ap_rst_n low asynchronously mid-stream at occupancy 10 -> outputs return to reset values before the next edge; the first write after release is the first value read out.

Source files
------------

// File: rtl/blk_a1b057.sv
// Show-ahead FIFO for the m_axi output path: SRL storage of DEPTH-1 entries
// plus a registered head stage, with occupancy, full/empty and write bypass.

module blk_a1b057_srl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];

    // Plain shift register without reset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

module blk_a1b057 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   num_data_valid,
    output logic [ADDR_WIDTH:0]   fifo_cap
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_CAP  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic                  push;
    logic                  pop;
    logic                  head_free;
    logic                  take_srl;
    logic                  bypass;
    logic                  srl_write;
    logic [ADDR_WIDTH:0]   n_srl;
    logic [ADDR_WIDTH:0]   n_srl_next;
    logic [ADDR_WIDTH:0]   num_reg;
    logic [ADDR_WIDTH:0]   num_next;
    logic                  dout_valid;
    logic                  full_n_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    // The head register is refilled whenever it is empty or being consumed;
    // with nothing queued in the SRL an incoming write goes straight to it.
    always_comb begin
        push       = if_write & full_n_reg;
        pop        = if_read & dout_valid;
        head_free  = ~dout_valid | pop;
        take_srl   = head_free & (n_srl != CNT_ZERO);
        bypass     = head_free & (n_srl == CNT_ZERO) & push;
        srl_write  = push & ~bypass;
        rd_addr    = n_srl[ADDR_WIDTH-1:0] - ADDR_ONE;

        n_srl_next = n_srl;
        if (srl_write && !take_srl) begin
            n_srl_next = n_srl + CNT_ONE;
        end else if (!srl_write && take_srl) begin
            n_srl_next = n_srl - CNT_ONE;
        end

        num_next = num_reg;
        if (push && !pop) begin
            num_next = num_reg + CNT_ONE;
        end else if (!push && pop) begin
            num_next = num_reg - CNT_ONE;
        end
    end

    blk_a1b057_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk      (ap_clk),
        .shift_en (srl_write),
        .din      (if_din),
        .addr     (rd_addr),
        .dout     (srl_dout)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            n_srl      <= '0;
            num_reg    <= '0;
            dout_valid <= 1'b0;
            full_n_reg <= 1'b1;
            dout_reg   <= '0;
        end else begin
            n_srl      <= n_srl_next;
            num_reg    <= num_next;
            full_n_reg <= (num_next != CNT_CAP);
            if (take_srl) begin
                dout_reg   <= srl_dout;
                dout_valid <= 1'b1;
            end else if (bypass) begin
                dout_reg   <= if_din;
                dout_valid <= 1'b1;
            end else if (head_free) begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign if_full_n      = full_n_reg;
    assign if_empty_n     = dout_valid;
    assign if_dout        = dout_reg;
    assign num_data_valid = num_reg;
    assign fifo_cap       = CNT_CAP;

endmodule

// File: tb/tb_blk_a1b057.sv
// Directed bench for the show-ahead output FIFO: a vector table for basic
// push/pop/bypass behaviour plus sequences for fill, drain and reset.

module tb_blk_a1b057;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [31:0] din;
    logic        full_n;
    logic        rd;
    logic [31:0] dout;
    logic        empty_n;
    logic [6:0]  num;
    logic [6:0]  cap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] din;
        logic        rd;
        logic        exp_empty_n;
        logic        exp_full_n;
        logic [31:0] exp_dout;
        logic [6:0]  exp_num;
    } vec_t;

    vec_t vecs [8];

    blk_a1b057 dut (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .if_write       (wr),
        .if_din         (din),
        .if_full_n      (full_n),
        .if_read        (rd),
        .if_dout        (dout),
        .if_empty_n     (empty_n),
        .num_data_valid (num),
        .fifo_cap       (cap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the active edge; outputs are sampled there too.
    task automatic apply_stimulus(input logic w, input logic [31:0] d, input logic r);
        wr  = w;
        din = d;
        rd  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic e, input logic f,
                               input logic [31:0] d, input logic [6:0] n);
        check_output({tag, ".empty_n"}, {31'b0, empty_n}, {31'b0, e});
        check_output({tag, ".full_n"},  {31'b0, full_n},  {31'b0, f});
        check_output({tag, ".dout"},    dout, d);
        check_output({tag, ".num"},     {25'b0, num}, {25'b0, n});
    endtask

    task automatic do_reset();
        wr = 1'b0; rd = 1'b0; din = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 7'd1};
        vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 7'd2};
        vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 7'd2};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h33, 7'd1};
        vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h33, 7'd0};
        vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h33, 7'd0};
        vecs[6] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h44, 7'd1};
        vecs[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h44, 7'd0};

        wr = 1'b0; rd = 1'b0; din = '0; rst_n = 1'b0;
        #12;
        check_state("reset", 1'b0, 1'b1, 32'h0, 7'd0);
        check_output("fifo_cap", {25'b0, cap}, 32'd64);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].din, vecs[i].rd);
            check_state($sformatf("vec%0d", i), vecs[i].exp_empty_n, vecs[i].exp_full_n,
                        vecs[i].exp_dout, vecs[i].exp_num);
        end

        // Fill to capacity, then an ignored write, then push+pop while full.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(1'b1, i, 1'b0);
            check_output($sformatf("fill%0d.num", i), {25'b0, num}, i + 1);
            check_output($sformatf("fill%0d.full_n", i), {31'b0, full_n}, (i == 63) ? 32'd0 : 32'd1);
        end
        check_output("full.dout", dout, 32'h0);
        apply_stimulus(1'b1, 32'hAA, 1'b0);
        check_state("overwrite", 1'b1, 1'b0, 32'h0, 7'd64);
        apply_stimulus(1'b1, 32'hBB, 1'b1);
        check_state("full_rw", 1'b1, 1'b1, 32'h1, 7'd63);

        for (int i = 1; i < 64; i++) begin
            check_output($sformatf("drain%0d.dout", i), dout, i);
            check_output($sformatf("drain%0d.empty_n", i), {31'b0, empty_n}, 32'd1);
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output($sformatf("drain%0d.num", i), {25'b0, num}, 63 - i);
        end
        check_state("drained", 1'b0, 1'b1, 32'h3F, 7'd0);

        // Straight drain from full in write order.
        do_reset();
        for (int i = 0; i < 64; i++) apply_stimulus(1'b1, i, 1'b0);
        for (int i = 0; i < 64; i++) begin
            check_output($sformatf("out%0d.dout", i), dout, i);
            apply_stimulus(1'b0, 32'h0, 1'b1);
            check_output($sformatf("out%0d.full_n", i), {31'b0, full_n}, 32'd1);
        end
        check_state("out_end", 1'b0, 1'b1, 32'h3F, 7'd0);

        // Steady state at occupancy 3 with push and pop every cycle.
        do_reset();
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, i, 1'b0);
        check_state("occ3", 1'b1, 1'b1, 32'h1, 7'd3);
        for (int k = 4; k <= 20; k++) begin
            apply_stimulus(1'b1, k, 1'b1);
            check_state($sformatf("stream%0d", k), 1'b1, 1'b1, k - 2, 7'd3);
        end

        // Asynchronous reset mid-stream at occupancy 10.
        do_reset();
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 32'h50 + i, 1'b0);
        check_state("occ10", 1'b1, 1'b1, 32'h50, 7'd10);
        wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 1'b1, 32'h0, 7'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst", 1'b0, 1'b1, 32'h0, 7'd0);
        apply_stimulus(1'b1, 32'h77, 1'b0);
        check_state("first_after_rst", 1'b1, 1'b1, 32'h77, 7'd1);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_state("empty_after_rst", 1'b0, 1'b1, 32'h77, 7'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
